// File: rtl/vec_alu_seq.sv
// vec_alu_seq: walks one vector command through an attached lane-wide ALU.
// It issues one chunk per cycle, element by element and chunk by chunk,
// merges each chunk result into a VLEN-bit result register and pulses
// done (with err for a rejected command) when the walk is over.
module vec_alu_seq #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [5:0]      opcode,
    input  logic [2:0]      vsew,
    input  logic [2:0]      op_type,
    input  logic [7:0]      vl,
    input  logic            hold,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_vsew,
    output logic [2:0]      alu_op_type,
    output logic [1:0]      alu_nb_lanes,
    output logic [9:0]      alu_index,
    output logic [3:0]      alu_in_reg_offset,
    input  logic [63:0]     alu_vd,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [VLEN-1:0] result
);

    localparam int LW = 1 << LANE_WIDTH;

    localparam logic [5:0] OP_VADD = 6'b000000;
    localparam logic [5:0] OP_VAND = 6'b001001;
    localparam logic [5:0] OP_VOR  = 6'b001010;
    localparam logic [5:0] OP_VXOR = 6'b001011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      opcode_q, opcode_d;
    logic [2:0]      vsew_q, vsew_d;
    logic [2:0]      op_type_q, op_type_d;
    logic            err_q, err_d;
    logic [7:0]      vl_eff_q, vl_eff_d;
    logic [7:0]      e_q, e_d;
    logic [3:0]      c_q, c_d;
    logic [VLEN-1:0] result_q, result_d;

    logic            cmd_legal;
    logic [7:0]      vl_eff_new;
    int              max_el;
    int              sew_log;
    int              sew_bits;
    int              w_bits;
    int              chunk_idx;
    logic [3:0]      c_last;
    logic [VLEN-1:0] vd_ext;
    logic [VLEN-1:0] vd_shift;
    logic [VLEN-1:0] lane_mask;
    logic            issue;

    // Zero-extend the ALU result to the result-register width.
    for (genvar gi = 0; gi < VLEN; gi++) begin : g_vd_ext
        if (gi < 64) begin : g_bit
            assign vd_ext[gi] = alu_vd[gi];
        end else begin : g_zero
            assign vd_ext[gi] = 1'b0;
        end
    end

    // Command check and effective element count for the incoming command.
    always_comb begin
        cmd_legal = 1'b0;
        case (opcode)
            OP_VADD, OP_VAND, OP_VOR, OP_VXOR: cmd_legal = (vsew <= 3'd3);
            default:                           cmd_legal = 1'b0;
        endcase
        max_el     = VLEN >> (int'(vsew[1:0]) + 3);
        vl_eff_new = (int'(vl) > max_el) ? 8'(max_el) : vl;
    end

    // Chunk geometry of the latched command and write mask of the current chunk.
    always_comb begin
        sew_log   = int'(vsew_q[1:0]) + 3;
        sew_bits  = 1 << sew_log;
        w_bits    = (sew_bits < LW) ? sew_bits : LW;
        c_last    = (sew_log > LANE_WIDTH) ? 4'((1 << (sew_log - LANE_WIDTH)) - 1) : 4'd0;
        chunk_idx = int'(e_q) * sew_bits + int'(c_q) * LW;
        vd_shift  = vd_ext << chunk_idx;
        lane_mask = '0;
        for (int i = 0; i < VLEN; i++) begin
            lane_mask[i] = (i >= chunk_idx) && (i < chunk_idx + w_bits);
        end
    end

    // Next-state logic: accept a command, walk chunks, then report completion.
    // A pause is only allowed on an element boundary so that the ALU carry
    // survives across all chunks of one element.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        vsew_d    = vsew_q;
        op_type_d = op_type_q;
        err_d     = err_q;
        vl_eff_d  = vl_eff_q;
        e_d       = e_q;
        c_d       = c_q;
        result_d  = result_q;
        issue     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_legal) begin
                        opcode_d  = opcode;
                        vsew_d    = vsew;
                        op_type_d = op_type;
                        vl_eff_d  = vl_eff_new;
                        e_d       = 8'd0;
                        c_d       = 4'd0;
                        err_d     = 1'b0;
                        result_d  = '0;
                        state_d   = (vl_eff_new == 8'd0) ? S_FIN : S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                if (!(hold && (c_q == 4'd0))) begin
                    issue    = 1'b1;
                    result_d = (result_q & ~lane_mask) | (vd_shift & lane_mask);
                    if (c_q == c_last) begin
                        c_d = 4'd0;
                        if (e_q == vl_eff_q - 8'd1) begin
                            e_d     = 8'd0;
                            state_d = S_FIN;
                        end else begin
                            e_d = e_q + 8'd1;
                        end
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            vsew_q    <= '0;
            op_type_q <= '0;
            err_q     <= 1'b0;
            vl_eff_q  <= '0;
            e_q       <= '0;
            c_q       <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            vsew_q    <= vsew_d;
            op_type_q <= op_type_d;
            err_q     <= err_d;
            vl_eff_q  <= vl_eff_d;
            e_q       <= e_d;
            c_q       <= c_d;
            result_q  <= result_d;
        end
    end

    assign alu_run           = issue;
    assign alu_opcode        = opcode_q;
    assign alu_vsew          = vsew_q;
    assign alu_op_type       = op_type_q;
    assign alu_nb_lanes      = 2'd0;
    assign alu_index         = (state_q == S_RUN) ? 10'(chunk_idx) : 10'd0;
    assign alu_in_reg_offset = (state_q == S_RUN) ? c_q : 4'd0;
    assign busy              = (state_q == S_RUN);
    assign done              = (state_q == S_FIN);
    assign err               = (state_q == S_FIN) && err_q;
    assign result            = result_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: a small 16-bit-lane ALU stand-in with a run-gated
// carry register, a table of directed commands, and hand-written sequences
// for hold, reset mid-operation and start while running.
module tb_vec_alu_seq;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [5:0]   opcode;
    logic [2:0]   vsew;
    logic [2:0]   op_type;
    logic [7:0]   vl;
    logic         hold;
    logic         alu_run;
    logic [5:0]   alu_opcode;
    logic [2:0]   alu_vsew;
    logic [2:0]   alu_op_type;
    logic [1:0]   alu_nb_lanes;
    logic [9:0]   alu_index;
    logic [3:0]   alu_in_reg_offset;
    logic [63:0]  alu_vd;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] result;

    vec_alu_seq #(.VLEN(128), .LANE_WIDTH(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .opcode(opcode),
        .vsew(vsew), .op_type(op_type), .vl(vl), .hold(hold),
        .alu_run(alu_run), .alu_opcode(alu_opcode), .alu_vsew(alu_vsew),
        .alu_op_type(alu_op_type), .alu_nb_lanes(alu_nb_lanes),
        .alu_index(alu_index), .alu_in_reg_offset(alu_in_reg_offset),
        .alu_vd(alu_vd), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    // ALU stand-in: 16-bit lane, carry kept only while run stays high.
    logic [127:0] op_a, op_b;
    logic         carry_q, carry_next, m_cin;
    logic [15:0]  m_mask, m_a, m_b, m_res;
    logic [16:0]  m_sum;
    logic [127:0] sh_a, sh_b;

    always_comb begin
        m_mask     = (alu_vsew[1:0] == 2'd0) ? 16'h00FF : 16'hFFFF;
        sh_a       = op_a >> alu_index;
        sh_b       = op_b >> alu_index;
        m_a        = sh_a[15:0] & m_mask;
        m_b        = sh_b[15:0] & m_mask;
        m_cin      = (alu_in_reg_offset != 4'd0) ? carry_q : 1'b0;
        m_sum      = {1'b0, m_a} + {1'b0, m_b} + {16'd0, m_cin};
        carry_next = (alu_vsew[1:0] == 2'd0) ? m_sum[8] : m_sum[16];
        case (alu_opcode)
            6'b001001: m_res = m_a & m_b;
            6'b001010: m_res = m_a | m_b;
            6'b001011: m_res = m_a ^ m_b;
            default:   m_res = m_sum[15:0];
        endcase
        alu_vd = {48'hDEADBEEFCAFE, (m_res & m_mask) | (16'hA5A5 & ~m_mask)};
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) carry_q <= 1'b0;
        else         carry_q <= alu_run ? carry_next : 1'b0;
    end

    // Monitor: cycle count, done pulses and a log of every issue.
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    logic        last_err = 1'b0;
    int          issue_total = 0;
    logic [9:0]  idx_log [512];
    logic [3:0]  off_log [512];

    always @(posedge clk) begin
        if (done) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
            last_err      = err;
        end
        if (alu_run) begin
            if (issue_total < 512) begin
                idx_log[issue_total] = alu_index;
                off_log[issue_total] = alu_in_reg_offset;
            end
            issue_total = issue_total + 1;
        end
        cyc = cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]   opc;
        logic [2:0]   sew;
        logic [7:0]   vl;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] exp_res;
        int           exp_iss;
        logic         exp_err;
    } vec_t;

    vec_t tbl [8];
    int   t_c0, t_d0, t_i0;

    task automatic start_op(input logic [5:0] o, input logic [2:0] s, input logic [7:0] n,
                            input logic [127:0] a, input logic [127:0] b);
        opcode  = o;
        vsew    = s;
        vl      = n;
        op_type = 3'b001;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        t_c0    = cyc;
        t_d0    = done_cnt;
        t_i0    = issue_total;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300 && done_cnt == t_d0; k++) begin
            @(posedge clk); #1;
        end
        chk({name, " done pulses"}, done_cnt - t_d0, 1);
    endtask

    initial begin
        tbl[0] = '{6'b000000, 3'd2, 8'd4,
                   128'h00000003_00000002_80000000_0000FFFF,
                   128'h00000004_FFFFFFFF_80000000_00000001,
                   128'h00000007_00000001_00000000_00010000, 8, 1'b0};
        tbl[1] = '{6'b001011, 3'd0, 8'd16,
                   128'h0123456789ABCDEF_FEDCBA9876543210,
                   128'hFFFFFFFFFFFFFFFF_0000000000000000,
                   128'hFEDCBA9876543210_FEDCBA9876543210, 16, 1'b0};
        tbl[2] = '{6'b001010, 3'd0, 8'd20,
                   128'h00FF00FF00FF00FF00FF00FF00FF00FF,
                   128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F,
                   128'h0FFF0FFF0FFF0FFF0FFF0FFF0FFF0FFF, 16, 1'b0};
        tbl[3] = '{6'b111111, 3'd0, 8'd4, 128'h1, 128'h1,
                   128'h0FFF0FFF0FFF0FFF0FFF0FFF0FFF0FFF, 0, 1'b1};
        tbl[4] = '{6'b000000, 3'd4, 8'd4, 128'h1, 128'h1,
                   128'h0FFF0FFF0FFF0FFF0FFF0FFF0FFF0FFF, 0, 1'b1};
        tbl[5] = '{6'b000000, 3'd0, 8'd0, 128'h1, 128'h1, 128'h0, 0, 1'b0};
        tbl[6] = '{6'b001001, 3'd1, 8'd5,
                   {128{1'b1}},
                   128'h1111_2222_3333_4444_5555_6666_7777_8888,
                   128'h0000_0000_0000_4444_5555_6666_7777_8888, 5, 1'b0};
        tbl[7] = '{6'b000000, 3'd3, 8'd3,
                   128'h0000000000000001_FFFFFFFFFFFFFFFF,
                   128'h0000000000000002_0000000000000001,
                   128'h0000000000000003_0000000000000000, 8, 1'b0};

        resetn = 1'b0; start = 1'b0; hold = 1'b0;
        opcode = '0; vsew = '0; op_type = '0; vl = '0;
        op_a = '0; op_b = '0;
        #12;
        chk("reset result", result, 0);
        chk("reset flags", {busy, done, err, alu_run}, 0);
        chk("reset alu fields", {alu_opcode, alu_vsew, alu_op_type, alu_nb_lanes, alu_index, alu_in_reg_offset}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int vi = 0; vi < 8; vi++) begin
            start_op(tbl[vi].opc, tbl[vi].sew, tbl[vi].vl, tbl[vi].a, tbl[vi].b);
            wait_done($sformatf("v%0d", vi));
            chk($sformatf("v%0d result", vi), result, tbl[vi].exp_res);
            chk($sformatf("v%0d issues", vi), issue_total - t_i0, tbl[vi].exp_iss);
            chk($sformatf("v%0d done cycle", vi), last_done_cyc - t_c0, tbl[vi].exp_iss + 1);
            chk($sformatf("v%0d err", vi), last_err, tbl[vi].exp_err);
            chk($sformatf("v%0d idle outs", vi), {busy, alu_run, alu_index, alu_in_reg_offset}, 0);
            if (vi == 0) begin
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("v0 index %0d", k), idx_log[t_i0 + k], 16 * k);
                    chk($sformatf("v0 offset %0d", k), off_log[t_i0 + k], k % 2);
                end
            end
            if (vi == 1) begin
                for (int k = 0; k < 16; k++) begin
                    chk($sformatf("v1 index %0d", k), idx_log[t_i0 + k], 8 * k);
                    chk($sformatf("v1 offset %0d", k), off_log[t_i0 + k], 0);
                end
            end
            $display("vector %0d: op=%b vsew=%0d vl=%0d result=%h", vi, tbl[vi].opc, tbl[vi].sew, tbl[vi].vl, result);
        end

        // hold raised mid-element: remaining chunks still issue, pause before element 1
        start_op(6'b000000, 3'd3, 8'd2,
                 128'h0000000000000001_FFFFFFFFFFFFFFFF,
                 128'h0000000000000002_0000000000000001);
        @(posedge clk); #1;
        chk("hold c1 offset", {alu_run, alu_in_reg_offset}, {1'b1, 4'd1});
        hold = 1'b1;
        #1;
        chk("hold c1 still runs", alu_run, 1);
        @(posedge clk); #1;
        chk("hold c2", {alu_run, alu_in_reg_offset}, {1'b1, 4'd2});
        @(posedge clk); #1;
        chk("hold c3", {alu_run, alu_in_reg_offset}, {1'b1, 4'd3});
        @(posedge clk); #1;
        chk("hold pause 1", {alu_run, busy}, 2'b01);
        @(posedge clk); #1;
        chk("hold pause 2", {alu_run, busy, alu_index}, {2'b01, 10'd64});
        @(posedge clk); #1;
        hold = 1'b0;
        #1;
        chk("hold resume", {alu_run, alu_index, alu_in_reg_offset}, {1'b1, 10'd64, 4'd0});
        wait_done("hold");
        chk("hold result", result, 128'h0000000000000003_0000000000000000);
        chk("hold issues", issue_total - t_i0, 8);
        chk("hold done cycle", last_done_cyc - t_c0, 11);
        $display("hold sequence: done cycle %0d result=%h", last_done_cyc - t_c0, result);

        // reset during issue 3 abandons the operation
        start_op(tbl[0].opc, tbl[0].sew, tbl[0].vl, tbl[0].a, tbl[0].b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst issue3", {alu_run, alu_index}, {1'b1, 10'd32});
        resetn = 1'b0;
        #1;
        chk("rst busy/run", {busy, alu_run, done}, 0);
        chk("rst result", result, 0);
        chk("rst index", {alu_index, alu_in_reg_offset}, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        chk("rst no done", done_cnt - t_d0, 0);
        $display("reset sequence: done pulses after abandon %0d", done_cnt - t_d0);

        // start during RUN is ignored
        start_op(tbl[0].opc, tbl[0].sew, tbl[0].vl, tbl[0].a, tbl[0].b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; opcode = 6'b001011; vl = 8'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore");
        chk("ignore result", result, tbl[0].exp_res);
        chk("ignore issues", issue_total - t_i0, 8);
        chk("ignore done cycle", last_done_cyc - t_c0, 9);
        chk("ignore opcode", alu_opcode, 6'b000000);
        repeat (4) begin @(posedge clk); #1; end
        chk("ignore no extra op", done_cnt - t_d0, 1);
        $display("start-ignore sequence: result=%h", result);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Sequencer that drives one vec_alu instance through a whole vector operation.
- It accepts a single operation command, then issues one lane-wide chunk per cycle, walking elements and sub-element chunks in order.
- It collects each chunk result into a VLEN-bit result register and signals completion.
- It sits between the vector decode/issue stage and the ALU, and owns the ALU's index, in_reg_offset and run inputs.

Parameters:
- VLEN, 128: vector register width in bits; also the width of the result register.
- LANE_WIDTH, 4: log2 of the ALU lane width; LW = 2^LANE_WIDTH bits. Must match the attached ALU.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command valid; sampled only in IDLE
- opcode  in  6  000000 vadd, 001001 vand, 001010 vor, 001011 vxor
- vsew  in  3  SEW = 8<<vsew; legal values 0..3
- op_type  in  3  001 VV, 010 VX, 100 VI; forwarded unchanged
- vl  in  8  requested element count
- hold  in  1  pause request, honoured only at element boundaries
- alu_run  out  1  ALU run
- alu_opcode  out  6  latched opcode
- alu_vsew  out  3  latched vsew
- alu_op_type  out  3  latched op_type
- alu_nb_lanes  out  2  tied to 0
- alu_index  out  10  bit index of the current chunk
- alu_in_reg_offset  out  4  chunk number within the current element
- alu_vd  in  64  ALU result, combinational in the same cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle completion pulse
- err  out  1  high together with done for an illegal command
- result  out  VLEN  assembled result vector

Behaviour:
- Reset: resetn low forces IDLE immediately and zeroes every output, including result. Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, RUN, FIN.
- IDLE, start=1, legal command:
  - Latch opcode, vsew, op_type.
  - Compute VL_EFF = min(vl, VLEN>>(vsew+3)).
  - Clear result to 0.
  - If VL_EFF = 0, go to FIN; otherwise go to RUN.
- IDLE, start=1, illegal command (opcode not in the four listed, or vsew > 3): go to FIN with err set; result is not modified.
- RUN and FIN ignore start.
- CPE (chunks per element) = 2^(vsew+3-LANE_WIDTH) if vsew+3 > LANE_WIDTH, else 1.
- W (bits kept per chunk) = min(SEW, LW).
- Issue cycle in RUN:
  - alu_run = 1.
  - alu_index = e*SEW + c*LW, where e is the element counter and c is the chunk counter.
  - alu_in_reg_offset = c.
  - result[alu_index +: W] is loaded from alu_vd[W-1:0] at the clock edge.
- Counter advance: c steps 0..CPE-1 and then wraps to 0 while e increments. After the issue with e = VL_EFF-1 and c = CPE-1, go to FIN.
- Carry chain: the ALU registers its carry every clock and loses it when run is low. Therefore chunks of one element are always issued back-to-back, and hold is never honoured while c != 0.
- hold: if hold = 1 when c = 0 and the next element is pending, no issue occurs. alu_run = 0, the counters freeze, and issue resumes on the first cycle hold = 0.
- FIN: done = 1 for exactly one cycle, err = 1 only for an illegal command, then return to IDLE.
- Latency with no hold: start accepted in cycle 0; issues in cycles 1..N where N = VL_EFF*CPE; done in cycle N+1. A new start is accepted in cycle N+2.
- Outputs between operations:
  - result holds its value until the next accepted legal start.
  - busy = 1 exactly in RUN.
  - alu_run = 0 outside issue cycles.
  - alu_index and alu_in_reg_offset are 0 in IDLE.
- Tail bits: bits of result beyond VL_EFF*SEW remain 0.

Test Plan:
1. vadd VV, vsew=2, vl=4, LW=16; element 0 operands 0x0000FFFF + 0x00000001 -> 8 issues; index 0,16,...,112; offsets 0,1,0,1,...; result[31:0] = 0x00010000; done in cycle 9.
2. vxor VV, vsew=0, vl=16 -> 16 issues; index step 8; offset always 0; each byte of result equals alu_vd[7:0] of its issue; done in cycle 17.
3. vsew=0 with vl=20 -> clamped to 16 issues. vl=0 -> no alu_run; done in cycle 1; result = 0.
4. vadd, vsew=3, vl=2; hold raised during offset 1 of element 0 -> offsets 2 and 3 still issue back-to-back; pause occurs before element 1; element 1 issues after hold drops; carry is correct (0xFFFFFFFFFFFFFFFF + 1 = 0).
5. opcode 111111 -> no alu_run; done and err high in cycle 1; previous result unchanged.
6. resetn low during issue 3 -> busy, alu_run and result go to 0 immediately. start during RUN is ignored, and the operation count is unchanged.
